// File: rtl/core_launch_ctrl_pkg.sv
// Shared types and defaults for the core launch controller.
package core_ctrl_pkg;

    localparam int NUM_CORES_DEF      = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int CNT_W_DEF          = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/core_launch_ctrl_if.sv
// Host/core-array handshake bundle for core_launch_ctrl.
interface core_launch_ctrl_if
    import core_ctrl_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF
);
    logic                 go;
    logic [NUM_CORES-1:0] core_en;
    logic [NUM_CORES-1:0] core_start;
    logic [NUM_CORES-1:0] core_done;
    logic [NUM_CORES-1:0] done_mask;
    logic                 busy;
    logic                 run_done;
    logic                 timeout_err;
    logic                 led_start;
    logic                 led_wait;
    logic                 led_done;
    logic                 led_err;

    modport master (
        output go, core_en, core_done,
        input  core_start, done_mask, busy, run_done, timeout_err,
               led_start, led_wait, led_done, led_err
    );

    modport slave (
        input  go, core_en, core_done,
        output core_start, done_mask, busy, run_done, timeout_err,
               led_start, led_wait, led_done, led_err
    );
endinterface

// File: rtl/core_launch_ctrl_run_timeout_counter.sv
// WAIT-phase timeout counter: clears, counts while enabled, saturates at TIMEOUT_CYCLES-1.
module run_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 2");
        end
        if ((TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_width
            $error("CNT_W too narrow for TIMEOUT_CYCLES");
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/core_launch_ctrl.sv
// Launch sequencer for the compute cores: start pulses, done collection, timeout.
// Optional STAGGER_START_EN spreads start pulses over NUM_CORES cycles.
module core_launch_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int NUM_CORES      = NUM_CORES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    core_launch_ctrl_if.slave bus
);
    // state    | meaning
    // ST_IDLE  | waiting for go with a non-empty enable mask
    // ST_START | issuing start pulses to enabled cores
    // ST_WAIT  | collecting done, timeout counter running
    // ST_DONE  | all enabled cores reported, run_done pulse
    // ST_ERR   | timeout reached, error latched

    state_t               state, state_nxt;
    logic [NUM_CORES-1:0] en_q, en_nxt;
    logic [NUM_CORES-1:0] mask_q, mask_nxt;
    logic [NUM_CORES-1:0] start_q, start_nxt;
    logic [NUM_CORES-1:0] capture;
    logic                 err_q, err_nxt;
    logic                 led_done_q, led_done_nxt;
    logic                 run_done_q, busy_q, led_start_q, led_wait_q;
    logic                 expired;

`ifdef STAGGER_START_EN
    localparam int                   IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [NUM_CORES-1:0] ONE      = NUM_CORES'(1);
    logic [IDX_W-1:0] idx_q, idx_nxt;
`endif

    run_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != ST_WAIT),
        .en      (state == ST_WAIT),
        .expired (expired)
    );

    assign capture = mask_q | (bus.core_done & en_q);

    always_comb begin
        state_nxt    = state;
        en_nxt       = en_q;
        mask_nxt     = mask_q;
        start_nxt    = '0;
        err_nxt      = err_q;
        led_done_nxt = led_done_q;
`ifdef STAGGER_START_EN
        idx_nxt      = idx_q;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.go && (bus.core_en != '0)) begin
                    state_nxt    = ST_START;
                    en_nxt       = bus.core_en;
                    mask_nxt     = '0;
                    err_nxt      = 1'b0;
                    led_done_nxt = 1'b0;
`ifdef STAGGER_START_EN
                    idx_nxt      = '0;
                    start_nxt    = bus.core_en & ONE;
`else
                    start_nxt    = bus.core_en;
`endif
                end
            end
            ST_START: begin
`ifdef STAGGER_START_EN
                mask_nxt = capture;
                if (idx_q == LAST_IDX) begin
                    state_nxt = ST_WAIT;
                end else begin
                    idx_nxt   = idx_q + 1'b1;
                    start_nxt = en_q & (ONE << idx_nxt);
                end
`else
                state_nxt = ST_WAIT;
`endif
            end
            ST_WAIT: begin
                mask_nxt = capture;
                // Completion has priority over a timeout in the same cycle.
                if (capture == en_q) begin
                    state_nxt    = ST_DONE;
                    led_done_nxt = 1'b1;
                end else if (expired) begin
                    state_nxt = ST_ERR;
                    err_nxt   = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            en_q        <= '0;
            mask_q      <= '0;
            start_q     <= '0;
            err_q       <= 1'b0;
            led_done_q  <= 1'b0;
            run_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            led_start_q <= 1'b0;
            led_wait_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            en_q        <= en_nxt;
            mask_q      <= mask_nxt;
            start_q     <= start_nxt;
            err_q       <= err_nxt;
            led_done_q  <= led_done_nxt;
            run_done_q  <= (state_nxt == ST_DONE);
            busy_q      <= (state_nxt == ST_START) || (state_nxt == ST_WAIT);
            led_start_q <= (state_nxt == ST_START);
            led_wait_q  <= (state_nxt == ST_WAIT);
        end
    end

`ifdef STAGGER_START_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_nxt;
        end
    end
`endif

    assign bus.core_start  = start_q;
    assign bus.done_mask   = mask_q;
    assign bus.busy        = busy_q;
    assign bus.run_done    = run_done_q;
    assign bus.timeout_err = err_q;
    assign bus.led_start   = led_start_q;
    assign bus.led_wait    = led_wait_q;
    assign bus.led_done    = led_done_q;
    assign bus.led_err     = err_q;

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Randomized bench for core_launch_ctrl against a run-level timing model.
module tb_core_launch_ctrl;
    localparam int N  = 4;
    localparam int T  = 1024;
    localparam int CW = 16;
`ifdef STAGGER_START_EN
    localparam int S = N;
`else
    localparam int S = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    core_launch_ctrl_if #(.NUM_CORES(N)) bus ();

    core_launch_ctrl #(
        .NUM_CORES      (N),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_mask = '0;
    logic         exp_ledd = 1'b0;
    logic         exp_err  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_out();
        return 32'({bus.core_start, bus.done_mask, bus.busy, bus.run_done, bus.timeout_err,
                    bus.led_start, bus.led_wait, bus.led_done, bus.led_err});
    endfunction

    function automatic logic [31:0] idle_exp();
        return 32'({{N{1'b0}}, exp_mask, 1'b0, 1'b0, exp_err, 1'b0, 1'b0, exp_ledd, exp_err});
    endfunction

    // One run from go: the model derives the end cycle and final mask from the done
    // schedule (WAIT-cycle index per core, -1 = never), then the bench checks every cycle.
    task automatic do_run(input logic [N-1:0] en, input int off [N], input logic [N-1:0] lvl,
                          input bit noise);
        bit           comp;
        int           maxd;
        int           kend;
        int           w;
        logic [N-1:0] mask;
        logic [N-1:0] st;
        logic [N-1:0] d;
        logic [N-1:0] one;
        comp = 1'b1;
        maxd = 0;
        mask = '0;
        one  = 1;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                if (off[i] >= 0 && off[i] < T) begin
                    mask[i] = 1'b1;
                    if (off[i] > maxd) maxd = off[i];
                end else begin
                    comp = 1'b0;
                end
            end
        end
        kend = comp ? (2 + S + maxd) : (1 + S + T);

        @(posedge clk); #1;
        bus.go      = 1'b1;
        bus.core_en = en;
        for (int k = 1; k <= kend + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1)
                chk("clear_on_go", 32'({bus.done_mask, bus.timeout_err, bus.led_done, bus.led_err}), 32'd0);
            st = '0;
            if (k <= S) st = (S == 1) ? en : (en & (one << (k - 1)));
            if (k < kend) begin
                chk("run_phase",
                    32'({bus.busy, bus.led_start, bus.led_wait, bus.run_done, bus.timeout_err, bus.core_start}),
                    32'({1'b1, k <= S, k > S, 1'b0, 1'b0, st}));
            end else if (k == kend) begin
                chk("run_end",
                    32'({bus.core_start, bus.busy, bus.run_done, bus.timeout_err, bus.led_done, bus.led_err, bus.done_mask}),
                    32'({{N{1'b0}}, 1'b0, comp, !comp, comp, !comp, mask}));
            end else begin
                exp_mask = mask;
                exp_ledd = comp;
                exp_err  = !comp;
                chk("run_after", all_out(), idle_exp());
            end
            // Requests while the controller is not idle must be ignored.
            if (k <= kend) begin
                bus.go      = 1'($urandom_range(0, 1));
                bus.core_en = N'($urandom);
            end else begin
                bus.go = 1'b0;
            end
            w = k - 1 - S;
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (en[i] && off[i] >= 0 && w >= 0)
                    if (lvl[i] ? (w >= off[i]) : (w == off[i])) d[i] = 1'b1;
            end
            if (noise) d = d | (N'($urandom) & ~en);
            bus.core_done = d;
        end
        bus.core_done = '0;
        bus.go        = 1'b0;
    endtask

    initial begin
        int           off [N];
        logic [N-1:0] en;
        int           r;

        bus.go        = 1'b0;
        bus.core_en   = '0;
        bus.core_done = '0;
        #1;
        chk("reset_outputs", all_out(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_release", all_out(), 32'd0);

        // Basic staggered completion.
        off = '{1, 4, 3, 7};
        do_run(4'b1111, off, 4'b0000, 1'b0);

        // Only disabled cores report: must time out with an empty mask.
        off = '{-1, -1, -1, -1};
        do_run(4'b0101, off, 4'b0000, 1'b1);

        // Following go clears the error.
        off = '{2, -1, 5, -1};
        do_run(4'b0101, off, 4'b0101, 1'b1);

        // Last done exactly on the final counter value.
        off = '{0, 10, 20, T - 1};
        do_run(4'b1111, off, 4'b0000, 1'b0);

        // Everything done in the first WAIT cycle.
        off = '{0, 0, 0, 0};
        do_run(4'b1011, off, 4'b1111, 1'b1);

        // go with an empty mask is ignored.
        @(posedge clk); #1;
        bus.go      = 1'b1;
        bus.core_en = '0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("empty_go", all_out(), idle_exp());
        end
        bus.go = 1'b0;

        // Async reset in the middle of WAIT.
        @(posedge clk); #1;
        bus.go      = 1'b1;
        bus.core_en = 4'b1111;
        for (int k = 1; k <= 2 + S; k++) begin
            @(posedge clk); #1;
            bus.go        = 1'b0;
            bus.core_done = (k - 1 - S == 0) ? 4'b0011 : 4'b0000;
        end
        chk("mask_before_rst", 32'({bus.busy, bus.done_mask}), 32'({1'b1, 4'b0011}));
        bus.core_done = '0;
        #2 rst = 1'b1;
        #1 chk("async_rst", all_out(), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold", all_out(), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        exp_mask = '0;
        exp_ledd = 1'b0;
        exp_err  = 1'b0;
        off = '{3, 1, 2, 6};
        do_run(4'b1111, off, 4'b1010, 1'b0);

        // Random runs.
        for (int n = 0; n < 20; n++) begin
            en = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 99);
                if (r < 4)      off[i] = -1;
                else if (r < 6) off[i] = T + $urandom_range(0, 5);
                else            off[i] = $urandom_range(0, 60);
            end
            do_run(en, off, N'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_launch_ctrl.md
Name: core_launch_ctrl

Overview:
Run controller for the accelerator's compute cores. On a launch request it pulses a start to every enabled core, collects per-core done indications, and detects a timeout. It reports phase on board status LEDs and sits between the host/boot logic and the core array, alongside the GPIO status block.

Parameters:
NUM_CORES, 4, number of compute cores sequenced
TIMEOUT_CYCLES, 1024, WAIT-phase cycles before declaring timeout (>=2)
CNT_W, 16, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
go  input  1  launch request; sampled only in IDLE
core_en  input  NUM_CORES  per-core enable mask; sampled into en_q on accepted go
core_start  output  NUM_CORES  per-core start pulses, one cycle each
core_done  input  NUM_CORES  per-core done; level or pulse, sticky-captured
done_mask  output  NUM_CORES  cores that have reported done in the current run
busy  output  1  high in START and WAIT
run_done  output  1  one-cycle pulse when all enabled cores are done
timeout_err  output  1  sticky error; cleared by the next accepted go
led_start  output  1  high in START
led_wait  output  1  high in WAIT
led_done  output  1  sticky after successful run; cleared by next accepted go
led_err  output  1  mirrors timeout_err

Behaviour:
- Reset asserted: all outputs 0, state IDLE, en_q/done_mask/counter 0. This holds immediately, mid-run included. In-flight start pulses are cut.
- States: IDLE, START, WAIT, DONE, ERR. All outputs are registered.
- IDLE:
  - go=1 and core_en!=0: latch en_q=core_en, clear done_mask/timeout_err/led_done, go to START.
  - go=1 and core_en==0: ignored, stay IDLE.
- START: core_start=en_q for exactly 1 cycle, then go to WAIT with counter=0. Latency from go to core_start is 1 cycle.
- WAIT:
  - done_mask <= done_mask | (core_done & en_q) every cycle. Done from disabled cores is ignored.
  - Counter increments each cycle.
  - If the next done_mask == en_q, go to DONE. This includes all cores reporting in the first WAIT cycle.
  - Else if counter == TIMEOUT_CYCLES-1, go to ERR.
  - Completion and timeout in the same cycle: completion wins.
- DONE: run_done=1 for 1 cycle, set led_done, return to IDLE.
- ERR: set timeout_err, return to IDLE. done_mask keeps the partial result for debug until the next accepted go.
- go while busy, in DONE, or in ERR: ignored, no queuing.
- core_done outside WAIT: ignored.
- Counter saturates and never wraps. Width rule is enforced by parameter check at elaboration.

Optional Feature:
Macro STAGGER_START_EN.
- Defined: START lasts NUM_CORES cycles; cycle i pulses core_start[i] only if en_q[i], bounding inrush current. WAIT and its counter begin after the last START cycle. done_mask capture is also active during START. Latency from go to the last possible start is NUM_CORES cycles.
- Undefined: all enabled cores start in the same single cycle, as described above.

Decomposition:
- Package core_ctrl_pkg holds: state encoding (3-bit enum IDLE=0, START=1, WAIT=2, DONE=3, ERR=4), default NUM_CORES, and default TIMEOUT_CYCLES.
- One natural sub-module: run_timeout_counter, with clear, enable, saturate, and an expired flag at TIMEOUT_CYCLES-1.

Test Plan:
- Basic run: reset, core_en=4'b1111, go pulse → core_start=4'b1111 for 1 cycle the cycle after go. Stagger dones (core0@+3, core2@+5, core1@+6, core3@+9) → run_done pulse 1 cycle after core3 done, led_done=1, busy=0.
- Partial mask: core_en=4'b0101; dones on cores 1 and 3 only → no completion, timeout at cycle 1024 of WAIT, led_err=1, done_mask=0. Next go clears the error.
- Simultaneous events: last done arrives on counter==TIMEOUT_CYCLES-1 → run_done=1, timeout_err=0.
- Ignored requests: go=1 with core_en=0 → stays IDLE, no start. A second go during WAIT → no effect on the counter or on core_start.
- Reset mid-run: rst asserted in WAIT with done_mask=4'b0011 → all outputs 0 asynchronously. A go after release starts a clean run.
- STAGGER_START_EN build: core_en=4'b1011 → core_start[0], [1], [3] pulse on START cycles 0, 1, 3; nothing on cycle 2. WAIT begins after cycle 3.
